// File: rtl/fx_bus_pkg.sv
// -----------------------------------------------------------------------------
// fx_bus_pkg
// Shared definitions for the fx register-bus master: command opcodes, address
// geometry (22-bit address, device select in [21:16]) and the master FSM
// state encoding.
// -----------------------------------------------------------------------------
package fx_bus_pkg;

  localparam int unsigned ADDR_W  = 22;
  localparam int unsigned DEV_MSB = 21;
  localparam int unsigned DEV_LSB = 16;

  localparam logic [7:0] OP_WR = 8'h01;
  localparam logic [7:0] OP_RD = 8'h02;

  typedef logic [ADDR_W-1:0] fx_addr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_A2,
    S_A1,
    S_A0,
    S_LEN,
    S_WDATA,
    S_RISSUE,
    S_RWAIT
  } state_t;

endpackage

// File: rtl/fx_bus_master_if.sv
// -----------------------------------------------------------------------------
// fx_bus_master_if
// Bundles the three channels the bus master talks on:
//   in_*   : command byte stream from the front-end FIFO (valid/ready)
//   out_*  : read-response byte stream (valid/ready)
//   fx_*   : register-bus write/read strobes, addresses and data
// Modports:
//   master : the bus master's view (drives in_ready, out_*, fx_* strobes)
//   slave  : the surrounding system's view (drives in_*, out_ready, fx_q)
// -----------------------------------------------------------------------------
interface fx_bus_master_if;
  import fx_bus_pkg::*;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  fx_addr_t   fx_waddr;
  logic       fx_wr;
  logic [7:0] fx_data;
  logic       fx_rd;
  fx_addr_t   fx_raddr;
  logic [7:0] fx_q;

  modport master (
    input  in_data, in_valid, out_ready, fx_q,
    output in_ready, out_data, out_valid,
           fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr
  );

  modport slave (
    output in_data, in_valid, out_ready, fx_q,
    input  in_ready, out_data, out_valid,
           fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr
  );

endinterface

// File: rtl/fx_rsp_slot.sv
// -----------------------------------------------------------------------------
// fx_rsp_slot
// One-entry valid/ready holding register for read-response bytes.
// Ports:
//   clk_sys, rst_n : clock, asynchronous active-low reset
//   load           : capture load_data (only asserted while the slot is empty)
//   load_data      : byte to capture
//   out_ready      : consumer accepts when out_valid & out_ready
//   out_data       : held response byte
//   out_valid      : slot full
// -----------------------------------------------------------------------------
module fx_rsp_slot (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_valid
);

  // NOTE: the data register is reset as well because out_data is a module
  // output that must read 0 after reset, not just a don't-care storage cell.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fx_bus_master.sv
// -----------------------------------------------------------------------------
// fx_bus_master
// Upstream master of the fx register bus. Parses a byte-stream command
// (opcode, 3 address bytes MSB first, length, then write data) into fx bus
// write and read cycles, with auto-incrementing bursts. Read data returns on
// a valid/ready byte stream through a one-entry response slot.
// Parameters:
//   RD_LAT : cycles from fx_rd to valid fx_q (1..4)
//   TO_CYC : idle-input cycles before a partial command is aborted
// Ports:
//   clk_sys, rst_n : clock, asynchronous active-low reset
//   bus            : fx_bus_master_if.master (command in, response out, fx bus)
//   busy           : state is not IDLE
//   err_cnt        : saturating count of bad opcodes (and timeouts)
// Optional feature: define FXB_TIMEOUT_EN to abort partial commands after
// TO_CYC idle input cycles.
// -----------------------------------------------------------------------------
module fx_bus_master
  import fx_bus_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned TO_CYC = 65535
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  fx_bus_master_if.master       bus,
  output logic                  busy,
  output logic [7:0]            err_cnt
);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("fx_bus_master: RD_LAT must be in 1..4");
  end
  if (TO_CYC < 1 || TO_CYC > 65535) begin : g_bad_to_cyc
    $error("fx_bus_master: TO_CYC must be in 1..65535");
  end

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  state_t     state_q, state_d;
  fx_addr_t   addr_q;
  logic [8:0] remain_q;
  logic [2:0] lat_q;
  logic       op_wr_q;
  logic [7:0] err_q;

  logic       fx_wr_q, fx_rd_q;
  fx_addr_t   waddr_q, raddr_q;
  logic [7:0] wdata_q;

  logic       in_ready, accept, last;
  logic       wr_fire, rd_issue, rd_capture;
  logic       bad_op, timeout, err_inc;
  logic       slot_valid;
  logic [7:0] slot_data;

  assign in_ready   = !(state_q == S_RISSUE || state_q == S_RWAIT);
  assign accept     = bus.in_valid && in_ready;
  assign last       = (remain_q == 9'd1);
  assign wr_fire    = (state_q == S_WDATA) && accept;
  // A read is issued only into an empty slot, so one read is outstanding at most
  // and a stalled consumer can never cause a captured byte to be overwritten.
  assign rd_issue   = (state_q == S_RISSUE) && !slot_valid;
  assign rd_capture = (state_q == S_RWAIT) && (lat_q == RD_LAT_C);
  assign err_inc    = bad_op || timeout;

`ifdef FXB_TIMEOUT_EN
  logic [15:0] idle_q;
  logic        idle_run;
  localparam logic [15:0] TO_LAST = 16'(TO_CYC - 1);

  // Only command-byte and write-data states wait on the input stream.
  assign idle_run = (state_q == S_A2) || (state_q == S_A1) || (state_q == S_A0) ||
                    (state_q == S_LEN) || (state_q == S_WDATA);
  assign timeout  = idle_run && !bus.in_valid && (idle_q == TO_LAST);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= 16'd0;
    end else if (!idle_run || accept || timeout) begin
      idle_q <= 16'd0;
    end else begin
      idle_q <= idle_q + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    bad_op  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.in_data == OP_WR || bus.in_data == OP_RD) state_d = S_A2;
          else                                               bad_op  = 1'b1;
        end
      end
      S_A2:     if (accept) state_d = S_A1;
      S_A1:     if (accept) state_d = S_A0;
      S_A0:     if (accept) state_d = S_LEN;
      S_LEN:    if (accept) state_d = op_wr_q ? S_WDATA : S_RISSUE;
      S_WDATA:  if (wr_fire && last) state_d = S_IDLE;
      S_RISSUE: if (rd_issue) state_d = S_RWAIT;
      S_RWAIT:  if (rd_capture) state_d = last ? S_IDLE : S_RISSUE;
      default:  state_d = S_IDLE;
    endcase
    if (timeout) state_d = S_IDLE;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      remain_q <= 9'd0;
      lat_q    <= 3'd0;
      op_wr_q  <= 1'b0;
      err_q    <= 8'h00;
      fx_wr_q  <= 1'b0;
      fx_rd_q  <= 1'b0;
      waddr_q  <= '0;
      raddr_q  <= '0;
      wdata_q  <= 8'h00;
    end else begin
      fx_wr_q <= wr_fire;
      fx_rd_q <= rd_issue;

      // Write/read address and data hold between strobes.
      if (wr_fire) begin
        waddr_q <= addr_q;
        wdata_q <= bus.in_data;
      end
      if (rd_issue) raddr_q <= addr_q;

      if (state_q == S_IDLE && accept) op_wr_q <= (bus.in_data == OP_WR);

      if (accept) begin
        unique case (state_q)
          S_A2:    addr_q[DEV_MSB:DEV_LSB] <= bus.in_data[5:0];
          S_A1:    addr_q[15:8]            <= bus.in_data;
          S_A0:    addr_q[7:0]             <= bus.in_data;
          // A length byte of 0 encodes a 256-access burst.
          S_LEN:   remain_q <= (bus.in_data == 8'h00) ? 9'd256 : {1'b0, bus.in_data};
          default: ;
        endcase
      end

      // Address wraps naturally at 22 bits.
      if (wr_fire || rd_issue)   addr_q   <= addr_q + 22'd1;
      if (wr_fire || rd_capture) remain_q <= remain_q - 9'd1;

      if (rd_issue)                lat_q <= 3'd0;
      else if (state_q == S_RWAIT) lat_q <= lat_q + 3'd1;

      if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end

  fx_rsp_slot u_rsp_slot (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .load      (rd_capture),
    .load_data (bus.fx_q),
    .out_ready (bus.out_ready),
    .out_data  (slot_data),
    .out_valid (slot_valid)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = slot_data;
  assign bus.out_valid = slot_valid;
  assign bus.fx_wr     = fx_wr_q;
  assign bus.fx_waddr  = waddr_q;
  assign bus.fx_data   = wdata_q;
  assign bus.fx_rd     = fx_rd_q;
  assign bus.fx_raddr  = raddr_q;

  assign busy    = (state_q != S_IDLE);
  assign err_cnt = err_q;

endmodule

// File: tb/tb_fx_bus_master.sv
// -----------------------------------------------------------------------------
// tb_fx_bus_master
// Self-checking bench for fx_bus_master. A register-slave model answers reads
// one cycle after fx_rd (stored data, or the low address byte if never
// written). Expected writes, read addresses and response bytes are queued when
// commands are sent and popped by a monitor as the DUT produces them.
// Define FXB_TIMEOUT_EN to also build the DUT with TO_CYC = 16 and run the
// idle-timeout scenario.
// -----------------------------------------------------------------------------
module tb_fx_bus_master;
  import fx_bus_pkg::*;

`ifdef FXB_TIMEOUT_EN
  localparam int unsigned TB_TO_CYC = 16;
`else
  localparam int unsigned TB_TO_CYC = 65535;
`endif

  typedef struct packed {
    fx_addr_t   addr;
    logic [7:0] data;
  } wr_t;

  logic       clk_sys = 1'b0;
  logic       rst_n   = 1'b1;
  logic       busy;
  logic [7:0] err_cnt;

  fx_bus_master_if bus ();

  fx_bus_master #(.RD_LAT(1), .TO_CYC(TB_TO_CYC)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus),
    .busy    (busy),
    .err_cnt (err_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int bp_mode      = 0;   // 0: always ready, 1: ready 1 of 4 cycles, 2: never ready
  int wr_pulses    = 0;
  int rd_pulses    = 0;
  int last_wr_cyc  = 0;
  int prev_wr_cyc  = 0;
  bit rd_outstanding = 1'b0;
  logic prev_out_valid = 1'b0;

  wr_t        exp_wr[$];
  fx_addr_t   exp_raddr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] mem [fx_addr_t];

  wr_t        mon_w;
  fx_addr_t   mon_a;
  logic [7:0] mon_d;

  // Consumer ready pattern
  always @(negedge clk_sys) begin
    cyc++;
    case (bp_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = (cyc % 4 == 0);
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Register slave model with one cycle of read latency, 0 when not reading
  always @(posedge clk_sys) begin
    if (bus.fx_wr === 1'b1) mem[bus.fx_waddr] = bus.fx_data;
    if (bus.fx_rd === 1'b1)
      bus.fx_q <= mem.exists(bus.fx_raddr) ? mem[bus.fx_raddr] : bus.fx_raddr[7:0];
    else
      bus.fx_q <= 8'h00;
  end

  // Scoreboard monitor, sampling mid-cycle
  always begin
    @(negedge clk_sys);
    #2;
    if (rst_n === 1'b1) begin
      if (bus.fx_wr === 1'b1) begin
        prev_wr_cyc = last_wr_cyc;
        last_wr_cyc = cyc;
        wr_pulses++;
        tests_run++;
        if (exp_wr.size() == 0) begin
          tests_failed++;
          $display("FAIL fx_wr_unexpected: got addr=%h data=%h, required no write",
                   bus.fx_waddr, bus.fx_data);
        end else begin
          mon_w = exp_wr.pop_front();
          if (bus.fx_waddr !== mon_w.addr || bus.fx_data !== mon_w.data || bus.fx_rd !== 1'b0) begin
            tests_failed++;
            $display("FAIL fx_wr: got addr=%h data=%h fx_rd=%b, required addr=%h data=%h fx_rd=0",
                     bus.fx_waddr, bus.fx_data, bus.fx_rd, mon_w.addr, mon_w.data);
          end
        end
      end
      if (bus.fx_rd === 1'b1) begin
        rd_pulses++;
        tests_run++;
        if (exp_raddr.size() == 0) begin
          tests_failed++;
          $display("FAIL fx_rd_unexpected: got raddr=%h, required no read", bus.fx_raddr);
        end else begin
          mon_a = exp_raddr.pop_front();
          if (bus.fx_raddr !== mon_a || rd_outstanding) begin
            tests_failed++;
            $display("FAIL fx_rd: got raddr=%h outstanding=%0d, required raddr=%h outstanding=0",
                     bus.fx_raddr, rd_outstanding, mon_a);
          end
        end
        rd_outstanding = 1'b1;
      end
      if (bus.out_valid === 1'b1 && prev_out_valid !== 1'b1) rd_outstanding = 1'b0;
      prev_out_valid = bus.out_valid;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        tests_run++;
        if (exp_rd.size() == 0) begin
          tests_failed++;
          $display("FAIL out_unexpected: got out_data=%h, required no byte", bus.out_data);
        end else begin
          mon_d = exp_rd.pop_front();
          if (bus.out_data !== mon_d) begin
            tests_failed++;
            $display("FAIL out_data: got %h, required %h", bus.out_data, mon_d);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 3000) begin
      @(negedge clk_sys);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL in_ready_wait: got in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
    end
    @(negedge clk_sys);
  endtask

  // Sends n bytes of cmd, most significant byte first, then idles the input.
  task automatic send_cmd(input logic [63:0] cmd, input int n);
    for (int i = n - 1; i >= 0; i--) send_byte(cmd[8*i +: 8]);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int n = 0;
    while ((exp_wr.size() != 0 || exp_rd.size() != 0 || exp_raddr.size() != 0 ||
            busy !== 1'b0 || bus.out_valid !== 1'b0) && n < max_cyc) begin
      @(negedge clk_sys);
      n++;
    end
    tests_run++;
    if (exp_wr.size() != 0 || exp_rd.size() != 0 || exp_raddr.size() != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_drain: got wr_left=%0d rd_left=%0d raddr_left=%0d busy=%b, required 0 0 0 0 within %0d cycles",
               name, exp_wr.size(), exp_rd.size(), exp_raddr.size(), busy, max_cyc);
    end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst_n = 1'b0;
    exp_wr.delete();
    exp_rd.delete();
    exp_raddr.delete();
    rd_outstanding = 1'b0;
    prev_out_valid = 1'b0;
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    @(negedge clk_sys);
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    @(negedge clk_sys);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
    end
    tests_run++;
    if ({bus.out_valid, bus.out_data} !== 9'h000) begin
      tests_failed++;
      $display("FAIL reset_out: got valid=%b data=%h, required 0 00", bus.out_valid, bus.out_data);
    end
    tests_run++;
    if ({bus.fx_wr, bus.fx_rd, bus.fx_waddr, bus.fx_raddr, bus.fx_data} !== 54'd0) begin
      tests_failed++;
      $display("FAIL reset_fx: got wr=%b rd=%b waddr=%h raddr=%h data=%h, required all 0",
               bus.fx_wr, bus.fx_rd, bus.fx_waddr, bus.fx_raddr, bus.fx_data);
    end
    tests_run++;
    if ({busy, err_cnt} !== 9'h000) begin
      tests_failed++;
      $display("FAIL reset_status: got busy=%b err_cnt=%h, required 0 00", busy, err_cnt);
    end
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic test_single_write_read();
    int wr_base;
    mem.delete();
    wr_base = wr_pulses;
    exp_wr.push_back({22'h010081, 8'h5A});
    send_cmd(64'h0101_0081_015A, 6);
    wait_done("single_write", 100);
    tests_run++;
    if (wr_pulses - wr_base != 1) begin
      tests_failed++;
      $display("FAIL single_write_count: got %0d fx_wr pulses, required 1", wr_pulses - wr_base);
    end
    exp_raddr.push_back(22'h010081);
    exp_rd.push_back(8'h5A);
    send_cmd(64'h02_0100_8101, 5);
    wait_done("single_read", 100);
  endtask

  task automatic test_burst_read(input int mode, input string name);
    int rd_base;
    do_reset();
    mem.delete();
    bp_mode = mode;
    rd_base = rd_pulses;
    for (int i = 0; i < 8; i++) begin
      exp_raddr.push_back(22'h010080 + 22'(i));
      exp_rd.push_back(8'h80 + 8'(i));
    end
    send_cmd(64'h02_0100_8008, 5);
    wait_done(name, 400);
    bp_mode = 0;
    tests_run++;
    if (rd_pulses - rd_base != 8) begin
      tests_failed++;
      $display("FAIL %s_count: got %0d fx_rd pulses, required 8", name, rd_pulses - rd_base);
    end
  endtask

  task automatic test_wrap_back_to_back();
    exp_wr.push_back({22'h3FFFFF, 8'h11});
    exp_wr.push_back({22'h000000, 8'h22});
    send_cmd(64'h01_3FFF_FF02_1122, 7);
    wait_done("wrap_write", 100);
    tests_run++;
    if (last_wr_cyc - prev_wr_cyc != 1) begin
      tests_failed++;
      $display("FAIL back_to_back_wr: got strobe spacing %0d cycles, required 1",
               last_wr_cyc - prev_wr_cyc);
    end
  endtask

  task automatic test_addr_mask();
    // Top two bits of the first address byte are ignored.
    exp_wr.push_back({22'h010020, 8'hAA});
    send_cmd(64'h01C1_0020_01AA, 6);
    wait_done("addr_mask", 100);
  endtask

  task automatic test_bad_opcode();
    do_reset();
    send_cmd(64'h7F, 1);
    exp_wr.push_back({22'h010010, 8'h33});
    send_cmd(64'h0101_0010_0133, 6);
    wait_done("bad_opcode_write", 100);
    tests_run++;
    if (err_cnt !== 8'h01) begin
      tests_failed++;
      $display("FAIL bad_opcode_err_cnt: got %h, required 01", err_cnt);
    end
  endtask

  task automatic test_err_saturate();
    do_reset();
    for (int i = 0; i < 300; i++) send_byte(8'h00);
    bus.in_valid = 1'b0;
    @(negedge clk_sys);
    tests_run++;
    if (err_cnt !== 8'hFF || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_saturate: got err_cnt=%h busy=%b, required FF 0", err_cnt, busy);
    end
  endtask

  task automatic test_len256_wrap();
    fx_addr_t a;
    do_reset();
    mem.delete();
    a = 22'h3FFF80;
    for (int i = 0; i < 256; i++) begin
      exp_raddr.push_back(a);
      exp_rd.push_back(a[7:0]);
      a = a + 22'd1;
    end
    send_cmd(64'h02_3FFF_8000, 5);
    wait_done("len256_read", 3000);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    bp_mode = 2;
    // Only the first read may issue: the slot stays full without a consumer.
    exp_raddr.push_back(22'h010090);
    send_cmd(64'h02_0100_9002, 5);
    while (bus.out_valid !== 1'b1 && n < 50) begin
      @(negedge clk_sys);
      n++;
    end
    tests_run++;
    if (bus.out_valid !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_pending: got out_valid=%b busy=%b, required 1 1", bus.out_valid, busy);
    end
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_discard: got out_valid=%b busy=%b, required 0 0", bus.out_valid, busy);
    end
    bp_mode = 0;
    do_reset();
    // Partial write command discarded by reset, then a clean write.
    send_cmd(64'h01_0100, 3);
    do_reset();
    exp_wr.push_back({22'h010020, 8'h44});
    send_cmd(64'h0101_0020_0144, 6);
    wait_done("reset_mid_recover", 100);
  endtask

`ifdef FXB_TIMEOUT_EN
  task automatic test_timeout();
    int wr_base;
    do_reset();
    wr_base = wr_pulses;
    send_cmd(64'h01_0100, 3);
    repeat (15) @(negedge clk_sys);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_early: got busy=%b after 15 idle cycles, required 1", busy);
    end
    @(negedge clk_sys);
    tests_run++;
    if (busy !== 1'b0 || err_cnt !== 8'h01 || wr_pulses != wr_base) begin
      tests_failed++;
      $display("FAIL timeout_abort: got busy=%b err_cnt=%h writes=%0d, required 0 01 0",
               busy, err_cnt, wr_pulses - wr_base);
    end
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_single_write_read();
    test_burst_read(0, "burst_read");
    test_burst_read(1, "back_pressure");
    test_wrap_back_to_back();
    test_addr_mask();
    test_bad_opcode();
    test_err_saturate();
    test_len256_wrap();
    test_reset_mid();
`ifdef FXB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded 50000 cycles, %0d tests run, %0d failed",
             tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end

endmodule
